// File: rtl/usb_crc5_check.sv
// USB token CRC5 generator/checker: parallel CRC5 over the 11-bit ADDR/ENDP payload,
// registered alongside a flag comparing it with the received CRC field.
module usb_crc5_check (
  input  logic        clk,
  input  logic        rst,
  input  logic [15:0] d,
  output logic        valid,
  output logic [4:0]  crc5_result
);

  localparam int unsigned PayloadW = 11;
  localparam logic [4:0]  CrcPoly  = 5'b00101;
  localparam logic [4:0]  CrcInit  = 5'b11111;

  logic [PayloadW-1:0] payload;
  logic [4:0]          rx_field;
  logic [4:0]          crc_reg;
  logic [4:0]          crc_field;
  logic                match;

  logic [4:0]          crc5_result_d, crc5_result_q;
  logic                valid_d, valid_q;

  assign payload  = d[PayloadW-1:0];
  assign rx_field = d[15:11];

  // Unrolled LFSR over the payload, LSB (first bit on the wire) first.
  always_comb begin
    logic fb;
    crc_reg = CrcInit;
    fb      = 1'b0;
    for (int i = 0; i < PayloadW; i++) begin
      fb      = payload[i] ^ crc_reg[4];
      crc_reg = {crc_reg[3:0], 1'b0};
      if (fb) begin
        crc_reg = crc_reg ^ CrcPoly;
      end
    end
  end

  // Complement, then bit-reverse so that bit 0 of the field is the MSB sent first.
  always_comb begin
    crc_field = '0;
    for (int i = 0; i < 5; i++) begin
      crc_field[i] = ~crc_reg[4-i];
    end
  end

  assign match = (rx_field == crc_field);

  always_comb begin
    crc5_result_d = crc_field;
    valid_d       = match;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      crc5_result_q <= 5'b00000;
      valid_q       <= 1'b0;
    end else begin
      crc5_result_q <= crc5_result_d;
      valid_q       <= valid_d;
    end
  end

  assign crc5_result = crc5_result_q;
  assign valid       = valid_q;

endmodule

// File: tb/tb_usb_crc5_check.sv
// Self-checking bench for usb_crc5_check: directed token cases plus randomised payloads
// against a polynomial-division CRC5 model.
module tb_usb_crc5_check;

  logic        clk;
  logic        rst;
  logic [15:0] d;
  logic        valid;
  logic [4:0]  crc5_result;

  int unsigned n_cmp;
  int unsigned n_bad;

  usb_crc5_check u_dut (
    .clk         (clk),
    .rst         (rst),
    .d           (d),
    .valid       (valid),
    .crc5_result (crc5_result)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check_val(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Reference: remainder of the augmented message modulo x^5+x^2+1, with the all-ones
  // preset folded into the first five message bits; result complemented and bit-reversed.
  function automatic logic [4:0] ref_crc5(input logic [10:0] pay);
    logic [15:0] dividend;
    logic [10:0] msg;
    logic [4:0]  rem;
    logic [4:0]  field;
    msg = '0;
    for (int i = 0; i < 11; i++) msg[10-i] = pay[i];
    msg      = msg ^ 11'b11111000000;
    dividend = {msg, 5'b00000};
    for (int k = 15; k >= 5; k--) begin
      if (dividend[k]) dividend = dividend ^ (16'b100101 << (k - 5));
    end
    rem = dividend[4:0];
    for (int i = 0; i < 5; i++) field[i] = ~rem[4-i];
    return field;
  endfunction

  task automatic drive_and_sample(input logic [15:0] word, input logic r);
    @(negedge clk);
    d   = word;
    rst = r;
    @(posedge clk);
    #1;
  endtask

  task automatic check_word(input string tag, input logic [15:0] word);
    logic [4:0] exp_crc;
    exp_crc = ref_crc5(word[10:0]);
    drive_and_sample(word, 1'b0);
    check_val({tag, "_crc"}, 32'(crc5_result), 32'(exp_crc));
    check_val({tag, "_valid"}, 32'(valid), 32'(word[15:11] == exp_crc));
  endtask

  localparam logic [15:0] BadWord  = 16'h0715;
  localparam logic [15:0] GoodWord = {5'b11101, 11'h715};

  initial begin
    n_cmp = 0;
    n_bad = 0;
    rst   = 1'b1;
    d     = 16'hFFFF;

    // Reset held for two cycles with arbitrary d
    for (int i = 0; i < 2; i++) begin
      drive_and_sample(16'hA5C3 ^ 16'(i), 1'b1);
      check_val("rst_crc", 32'(crc5_result), 32'h0);
      check_val("rst_valid", 32'(valid), 32'h0);
    end

    // Known examples, checked against constants as well as the model
    drive_and_sample(BadWord, 1'b0);
    check_val("bad_crc_const", 32'(crc5_result), 32'h1D);
    check_val("bad_valid_const", 32'(valid), 32'h0);
    for (int i = 0; i < 10; i++) check_word("bad_hold", BadWord);

    drive_and_sample(GoodWord, 1'b0);
    check_val("good_crc_const", 32'(crc5_result), 32'h1D);
    check_val("good_valid_const", 32'(valid), 32'h1);

    drive_and_sample(16'h0000, 1'b0);
    check_val("zero_crc_const", 32'(crc5_result), 32'h02);
    check_val("zero_valid_const", 32'(valid), 32'h0);
    drive_and_sample({5'b00010, 11'h000}, 1'b0);
    check_val("zero_good_valid", 32'(valid), 32'h1);
    check_val("zero_good_crc", 32'(crc5_result), 32'h02);

    // Back-to-back alternation: valid toggles every cycle
    for (int i = 0; i < 8; i++) begin
      drive_and_sample((i % 2 == 0) ? GoodWord : BadWord, 1'b0);
      check_val("b2b_valid", 32'(valid), (i % 2 == 0) ? 32'h1 : 32'h0);
      check_val("b2b_crc", 32'(crc5_result), 32'h1D);
    end

    // Mid-stream reset
    drive_and_sample(GoodWord, 1'b1);
    check_val("midrst_crc", 32'(crc5_result), 32'h0);
    check_val("midrst_valid", 32'(valid), 32'h0);
    check_word("post_rst", GoodWord);

    // Randomised payloads, half carrying the correct field
    for (int i = 0; i < 1000; i++) begin
      logic [10:0] pay;
      logic [4:0]  fld;
      pay = 11'($urandom);
      fld = (i % 2 == 0) ? ref_crc5(pay) : 5'($urandom);
      check_word("rand", {fld, pay});
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
